// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources; req to grant/tx_start is 1 cycle.
// Requests stay held until granted while a frame is in flight; `UART_TX_ARB_GAP_EN adds a GAP_CYCLES idle gap per frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDX_W         = 2,
  parameter int GAP_CYCLES    = 434,
  parameter int START_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     owner,
  output logic                 arb_busy,
  output logic                 tx_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** IDX_W) < NUM_REQ) begin : g_bad_req
    $error("uart_tx_arbiter: NUM_REQ/IDX_W out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_CYCLES out of range");
  end
  if (START_TIMEOUT < 2 || START_TIMEOUT > 255) begin : g_bad_to
    $error("uart_tx_arbiter: START_TIMEOUT out of range");
  end

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
`ifdef UART_TX_ARB_GAP_EN
  localparam logic [1:0] ST_GAP       = 2'd3;
  localparam logic [1:0] ST_POST      = ST_GAP;
`else
  localparam logic [1:0] ST_POST      = ST_IDLE;
`endif

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               tx_err_q, tx_err_d;
  logic [7:0]         to_cnt_q, to_cnt_d;
`ifdef UART_TX_ARB_GAP_EN
  logic [15:0]        gap_cnt_q, gap_cnt_d;
`endif

  logic               hi_found, lo_found;
  logic [IDX_W-1:0]   hi_w, lo_w, win;
  logic [7:0]         win_data;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_w     = '0;
    lo_w     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_w     = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_w     = IDX_W'(i);
        end
      end
    end
    win      = hi_found ? hi_w : lo_w;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win) win_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    tx_err_d   = 1'b0;
    to_cnt_d   = to_cnt_q;
`ifdef UART_TX_ARB_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lo_found) begin
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (IDX_W'(i) == win);
          tx_start_d = 1'b1;
          tx_data_d  = win_data;
          owner_d    = win;
          ptr_d      = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
          to_cnt_d   = '0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == 8'(START_TIMEOUT - 1)) begin
          tx_err_d = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_POST;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_POST;
      end
`ifdef UART_TX_ARB_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      owner_q    <= '0;
      tx_err_q   <= 1'b0;
      to_cnt_q   <= '0;
`ifdef UART_TX_ARB_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      owner_q    <= owner_d;
      tx_err_q   <= tx_err_d;
      to_cnt_q   <= to_cnt_d;
`ifdef UART_TX_ARB_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign owner    = owner_q;
  assign tx_err   = tx_err_q;
  assign arb_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: per-requester byte queues, a round-robin
// order model, a UART transmitter busy model and a decoupled output monitor.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ       = 4;
  localparam int IDX_W         = 2;
  localparam int GAP_CYCLES    = 434;
  localparam int START_TIMEOUT = 8;
`ifdef UART_TX_ARB_GAP_EN
  localparam int EXP_GAP = GAP_CYCLES + 1;
`else
  localparam int EXP_GAP = 1;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [IDX_W-1:0]     owner;
  logic                 arb_busy;
  logic                 tx_err;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .GAP_CYCLES(GAP_CYCLES), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner),
    .arb_busy(arb_busy), .tx_err(tx_err)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[NUM_REQ][$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  int         err_pulses = 0;
  bit         busy_en = 1'b1;
  bit         expect_to = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] b);
    src_q[i].push_back(b);
  endtask

  // Expected service order: repeatedly take the first requester at or after the
  // pointer (cyclically) that still has bytes; the pointer moves past each winner.
  task automatic predict();
    int   pos[NUM_REQ];
    int   left;
    exp_t e;
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      left += src_q[i].size();
    end
    while (left > 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (pos[idx] < src_q[idx].size()) begin
          e.idx  = idx;
          e.data = src_q[idx][pos[idx]];
          exp_q.push_back(e);
          pos[idx]++;
          left--;
          m_ptr = (idx + 1) % NUM_REQ;
          break;
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int budget;
    int n;
    budget = 600 * (exp_q.size() + 2);
    n = 0;
    while ((exp_q.size() != 0 || arb_busy || req != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Requesters: hold req+byte until grant is seen, then present the next byte or drop.
  initial begin
    req      = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rst_n) src_q[i].delete();
        else if (grant[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req[i] = (src_q[i].size() > 0);
        if (src_q[i].size() > 0) req_data[8*i +: 8] = src_q[i][0];
      end
    end
  end

  // Transmitter: busy rises 0..2 cycles after tx_start and lasts a random frame length.
  initial begin
    bit tx_pend;
    int tx_dly;
    int tx_len;
    tx_busy = 1'b0;
    tx_pend = 1'b0;
    tx_dly  = 0;
    tx_len  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0;
        tx_pend = 1'b0;
      end else if (tx_busy) begin
        if (tx_len == 0) tx_busy = 1'b0;
        else tx_len--;
      end else begin
        if (tx_start && busy_en && !tx_pend) begin
          tx_pend = 1'b1;
          tx_dly  = $urandom_range(0, 2);
          tx_len  = $urandom_range(2, 10);
        end
        if (tx_pend) begin
          if (tx_dly == 0) begin
            tx_busy = 1'b1;
            tx_pend = 1'b0;
          end else begin
            tx_dly--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every launch and checks holds, gaps and timeouts.
  initial begin
    logic [7:0] last_data;
    int         launch_cyc;
    int         fall_cyc;
    bit         prev_busy;
    bit         fall_pend;
    exp_t       e;
    last_data  = 8'h00;
    launch_cyc = 0;
    fall_cyc   = 0;
    prev_busy  = 1'b0;
    fall_pend  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        prev_busy = 1'b0;
        fall_pend = 1'b0;
        last_data = 8'h00;
        continue;
      end
      if (prev_busy && !tx_busy && req != '0) begin
        fall_pend = 1'b1;
        fall_cyc  = cyc;
      end
      prev_busy = tx_busy;
      if (tx_start || grant != '0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_launch", 32'({grant, tx_start}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant", 32'(grant), 32'(1) << e.idx);
          chk("tx_start", 32'(tx_start), 32'd1);
          chk("tx_data", 32'(tx_data), 32'(e.data));
          chk("owner", 32'(owner), 32'(e.idx));
          chk("start_while_busy", 32'(tx_busy), 32'd0);
          if (fall_pend) begin
            chk("restart_gap", 32'(cyc - fall_cyc), 32'(EXP_GAP));
            fall_pend = 1'b0;
          end
          last_data  = tx_data;
          launch_cyc = cyc;
        end
      end else if (arb_busy) begin
        chk("tx_data_hold", 32'(tx_data), 32'(last_data));
      end
      if (tx_err) begin
        err_pulses++;
        chk("tx_err_expected", 32'(expect_to), 32'd1);
        chk("timeout_latency", 32'(cyc - launch_cyc), 32'(START_TIMEOUT));
      end
    end
  end

  initial begin
    int n;
    int cnt;
    bit any;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NUM_REQ; i++) push_byte(i, 8'(16 + i));
    predict();
    drain("drain_all_four");

    push_byte(1, 8'hA5);
    predict();
    drain("drain_single");

    for (int k = 0; k < 4; k++) begin
      push_byte(0, 8'($urandom));
      push_byte(2, 8'($urandom));
    end
    predict();
    drain("drain_alt_0_2");

    for (int r = 0; r < 10; r++) begin
      any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          any = 1'b1;
          cnt = $urandom_range(1, 3);
          for (int b = 0; b < cnt; b++) push_byte(i, 8'($urandom));
        end
      end
      if (!any) push_byte($urandom_range(0, NUM_REQ - 1), 8'($urandom));
      predict();
      drain("drain_random");
    end

    busy_en    = 1'b0;
    expect_to  = 1'b1;
    err_pulses = 0;
    push_byte(3, 8'($urandom));
    predict();
    drain("drain_timeout");
    chk("tx_err_pulses", 32'(err_pulses), 32'd1);
    busy_en   = 1'b1;
    expect_to = 1'b0;
    push_byte(0, 8'($urandom));
    predict();
    drain("drain_after_timeout");

    push_byte(1, 8'h5A);
    predict();
    n = 0;
    while (!(tx_busy && arb_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("reach_wait_done", 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd0);
    chk("midrst_arb_busy", 32'(arb_busy), 32'd0);
    chk("midrst_tx_err", 32'(tx_err), 32'd0);
    exp_q.delete();
    m_ptr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_byte(1, 8'h3C);
    push_byte(3, 8'hC3);
    predict();
    drain("drain_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
